// File: rtl/instr_byte_queue_if.sv
// Bus between fetch/decode and the instruction byte queue: fetch push side,
// decode window/consume side, flush and status.
interface instr_byte_queue_if #(
    parameter int FETCH_BYTES  = 4,
    parameter int WINDOW_BYTES = 11,
    parameter int DEPTH_BYTES  = 16
);
    localparam int CNT_W = $clog2(DEPTH_BYTES + 1);
    localparam int NB_W  = $clog2(FETCH_BYTES + 1);

    // Handshakes: a fetch word moves on a cycle where fetch_valid && fetch_ready;
    // upstream holds the word until then. An instruction retires on a cycle where
    // consume_valid && window_valid; consume_valid while !window_valid is ignored.
    logic                      fetch_valid;
    logic                      fetch_ready;
    logic [FETCH_BYTES*8-1:0]  fetch_data;
    logic [NB_W-1:0]           fetch_nbytes;
    logic                      fetch_last;
    logic                      flush;
    logic                      window_valid;
    logic [WINDOW_BYTES*8-1:0] window;
    logic [CNT_W-1:0]          count;
    logic                      consume_valid;
    logic [3:0]                consume_len;
    logic                      drained;
    logic                      error;

    modport master (
        output fetch_valid, fetch_data, fetch_nbytes, fetch_last, flush,
               consume_valid, consume_len,
        input  fetch_ready, window_valid, window, count, drained, error
    );

    modport slave (
        input  fetch_valid, fetch_data, fetch_nbytes, fetch_last, flush,
               consume_valid, consume_len,
        output fetch_ready, window_valid, window, count, drained, error
    );
endinterface

// File: rtl/instr_byte_queue.sv
// Byte-granular instruction prefetch queue: circular byte buffer filled by fetch
// words, presenting an instruction-aligned window to operand decode.
module instr_byte_queue #(
    parameter int DEPTH_BYTES  = 16,
    parameter int FETCH_BYTES  = 4,
    parameter int WINDOW_BYTES = 11
) (
    input logic clk,
    input logic rst,
    instr_byte_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = $clog2(DEPTH_BYTES + 1);
    localparam int NB_W  = $clog2(FETCH_BYTES + 1);

    logic [7:0]       mem [DEPTH_BYTES];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             eof;
    logic             err;

    logic             ready;
    logic             wv;
    logic             push;
    logic             take;
    logic             over;
    logic [NB_W-1:0]  push_nb;
    logic [CNT_W-1:0] push_amt;
    logic [CNT_W-1:0] cons_amt;
    logic [CNT_W-1:0] cnt_next;
    logic [WINDOW_BYTES*8-1:0] win;

    // Control is derived only from registered state; nothing bypasses the buffer.
    always_comb begin
        ready   = (cnt <= CNT_W'(DEPTH_BYTES - FETCH_BYTES)) && !eof && !err;
        wv      = !err && ((cnt >= CNT_W'(WINDOW_BYTES)) || (eof && cnt != '0));
        push_nb = q.fetch_nbytes;
        if (q.fetch_nbytes == '0 || q.fetch_nbytes > NB_W'(FETCH_BYTES)) begin
            push_nb = NB_W'(FETCH_BYTES);
        end
        push     = q.fetch_valid && ready;
        take     = q.consume_valid && wv;
        // Over-consume is judged against the pre-push count.
        over     = take && (CNT_W'(q.consume_len) > cnt);
        push_amt = push ? CNT_W'(push_nb) : '0;
        cons_amt = (take && !over) ? CNT_W'(q.consume_len) : '0;
        cnt_next = cnt + push_amt - cons_amt;
    end

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            eof    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(push_amt);
                if (q.fetch_last) begin
                    eof <= 1'b1;
                end
            end
            if (over) begin
                err <= 1'b1;
            end else begin
                rd_ptr <= rd_ptr + PTR_W'(cons_amt);
            end
            cnt <= cnt_next;
        end
    end

    // Byte storage carries no reset; bytes beyond count are masked in the window.
    always_ff @(posedge clk) begin
        if (push && !q.flush && !rst) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                if (NB_W'(i) < push_nb) begin
                    mem[wr_ptr + PTR_W'(i)] <= q.fetch_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < WINDOW_BYTES; k++) begin
            if (CNT_W'(k) < cnt) begin
                win[8*k +: 8] = mem[rd_ptr + PTR_W'(k)];
            end
        end
    end

    assign q.fetch_ready  = ready;
    assign q.window_valid = wv;
    assign q.window       = win;
    assign q.count        = cnt;
    assign q.drained      = eof && (cnt == '0);
    assign q.error        = err;
endmodule

// File: doc/instr_byte_queue.md
Name: instr_byte_queue

Overview:
- Byte-granular instruction prefetch queue directly upstream of operand-signal decode.
- Accepts fetched 32-bit words and stores them in a circular byte buffer.
- Presents an 88-bit window aligned to the current instruction start; this window is the `unescaped_instr` input of operand decode.
- Retires whole instructions when the decode stage reports their total length (prefix/opcode bytes plus ModR/M, SIB and `imm_disp_len`).

Parameters:
- DEPTH_BYTES, 16, buffer capacity in bytes; power of two, ≥ WINDOW_BYTES+FETCH_BYTES.
- FETCH_BYTES, 4, bytes per fetch word.
- WINDOW_BYTES, 11, bytes presented to decode.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch word present.
- fetch_ready  out  1  queue can accept a word this cycle.
- fetch_data  in  32  fetch word; byte 0 in [7:0].
- fetch_nbytes  in  3  valid bytes in word, 1..4, low-order first.
- fetch_last  in  1  word is the final word of the stream.
- flush  in  1  discard all contents (redirect).
- window_valid  out  1  window holds a decodable instruction.
- window  out  88  bytes rd_ptr..rd_ptr+10; byte 0 in [7:0]; bytes at offset ≥ count read as 0.
- count  out  5  bytes currently held, 0..16.
- consume_valid  in  1  decode retires an instruction.
- consume_len  in  4  bytes retired, 1..15.
- drained  out  1  stream ended and queue empty.
- error  out  1  sticky over-consume error.

Behaviour:
- State:
  - 16x8 byte array.
  - rd_ptr and wr_ptr, 4 bits each, modulo DEPTH_BYTES.
  - count, 5 bits.
  - eof flag.
  - error flag.
- Reset:
  - rd_ptr = wr_ptr = count = 0; eof = 0; error = 0.
  - Outputs: fetch_ready = 1, window_valid = 0, window = 0, count = 0, drained = 0, error = 0.
  - Byte array contents are don't-care.
- Combinational outputs, all derived from registered state only. There is no bypass, so a pushed byte is visible in `window` the cycle after acceptance.
  - fetch_ready = (DEPTH_BYTES − count ≥ FETCH_BYTES) && !eof && !error.
  - window_valid = !error && (count ≥ WINDOW_BYTES || (eof && count ≠ 0)).
  - drained = eof && count == 0.
- Push, when fetch_valid && fetch_ready:
  - Write bytes 0..fetch_nbytes−1 at wr_ptr, wr_ptr+1, … with wrap-around.
  - wr_ptr += fetch_nbytes.
  - If fetch_last, set eof.
  - fetch_nbytes of 0 or >4 is treated as 4; this is a bench assertion, not a design case.
  - fetch_valid while !fetch_ready: the word is ignored and no state changes. The upstream stage holds the word.
- Consume, when consume_valid && window_valid:
  - If consume_len ≤ count: rd_ptr += consume_len.
  - If consume_len > count: no pointer move, error ← 1 (sticky until rst or flush).
  - consume_len == 0: no-op, no error.
  - consume_valid while !window_valid: ignored.
- Simultaneous push and consume:
  - count_next = count + pushed − consumed, evaluated on registered count.
  - The over-consume check uses the pre-push count.
- Flush:
  - Same-cycle effect: rd_ptr = wr_ptr = count = 0; eof = 0; error = 0.
  - Flush has priority over push and consume in the same cycle; both are dropped.
- rst during any activity gives reset state next cycle; it has priority over flush.
- Window assembly: byte k = (k < count) ? mem[(rd_ptr + k) mod DEPTH] : 8'h00, for k = 0..10.
- Invariant: count ≤ DEPTH_BYTES at all times. The bench asserts it and asserts wr_ptr − rd_ptr ≡ count mod DEPTH.

Test Plan:
- Reset, then push 0x03020100, 0x07060504, 0x0B0A0908 on consecutive cycles:
  - count 4, 8, 12.
  - window_valid rises the cycle after the third push.
  - window[87:0] = 0x0A09080706050403020100.
- From that state, consume_len = 3 and push 0x0F0E0D0C in the same cycle:
  - count 13.
  - window[7:0] = 0x03.
  - fetch_ready = 0 (16 − 13 < 4).
- Wrap-around: keep pushing an incrementing byte stream while consuming 4 bytes per cycle for 10 cycles:
  - window[7:0] always equals the expected next byte.
  - wr_ptr wraps from 15 to 0 with no byte corruption.
- Over-consume: with count = 11, consume_len = 12:
  - error = 1, count stays 11, window_valid = 0, fetch_ready = 0.
  - flush the next cycle → error = 0, count = 0.
- End of stream: push 0x00CCBBAA with fetch_nbytes = 3 and fetch_last = 1 into an empty queue:
  - Next cycle: window_valid = 1, window = 0x...00CCBBAA with upper bytes 0.
  - consume_len = 3 → drained = 1.
- Flush with simultaneous push and consume at count = 12:
  - Next cycle count = 0, window_valid = 0, fetch_ready = 1.
  - The pushed word is absent.
